// File: rtl/mem_wb_pipe_if.sv
// MEM->WB pipeline bus: stage control, MEM writeback channels in, WB channels out.
// The forwarding port group exists only when WB_FWD_EN is defined.
interface mem_wb_pipe_if #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_CH  = 1,
   parameter int STALL_W = 6,
   parameter int CNT_W   = 32
);
   logic                       rdy;
   logic [STALL_W-1:0]         stall;
   logic                       flush;
   logic [NUM_CH*DATA_W-1:0]   mem_rd_data;
   logic [NUM_CH*ADDR_W-1:0]   mem_rd_addr;
   logic [NUM_CH-1:0]          mem_rd_e;
   logic [NUM_CH*DATA_W-1:0]   wb_rd_data;
   logic [NUM_CH*ADDR_W-1:0]   wb_rd_addr;
   logic [NUM_CH-1:0]          wb_rd_e;
   logic [CNT_W-1:0]           wb_retire_cnt;
`ifdef WB_FWD_EN
   logic [ADDR_W-1:0]          fwd_addr;
   logic                       fwd_hit;
   logic [DATA_W-1:0]          fwd_data;

   modport master (
      output rdy, stall, flush, mem_rd_data, mem_rd_addr, mem_rd_e, fwd_addr,
      input  wb_rd_data, wb_rd_addr, wb_rd_e, wb_retire_cnt, fwd_hit, fwd_data
   );
   modport slave (
      input  rdy, stall, flush, mem_rd_data, mem_rd_addr, mem_rd_e, fwd_addr,
      output wb_rd_data, wb_rd_addr, wb_rd_e, wb_retire_cnt, fwd_hit, fwd_data
   );
`else
   modport master (
      output rdy, stall, flush, mem_rd_data, mem_rd_addr, mem_rd_e,
      input  wb_rd_data, wb_rd_addr, wb_rd_e, wb_retire_cnt
   );
   modport slave (
      input  rdy, stall, flush, mem_rd_data, mem_rd_addr, mem_rd_e,
      output wb_rd_data, wb_rd_addr, wb_rd_e, wb_retire_cnt
   );
`endif
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: NUM_CH writeback channels, bubble/flush/hold, x0 and
// duplicate-rd suppression, retire counter. Optional WB lookup port under WB_FWD_EN.
module mem_wb_pipe #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_CH  = 1,
   parameter int STALL_W = 6,
   parameter int STAGE   = 4,
   parameter int CNT_W   = 32
) (
   input  logic          clk,
   input  logic          rst,
   mem_wb_pipe_if.slave  io_bus
);

   if (STAGE + 1 >= STALL_W) begin : g_bad_stage
      $error("mem_wb_pipe: STAGE+1 must be below STALL_W");
   end

   logic [NUM_CH-1:0][DATA_W-1:0] w_mem_data;
   logic [NUM_CH-1:0][ADDR_W-1:0] w_mem_addr;
   logic [NUM_CH-1:0][DATA_W-1:0] r_wb_data;
   logic [NUM_CH-1:0][ADDR_W-1:0] r_wb_addr;
   logic [NUM_CH-1:0]             r_wb_e;
   logic [NUM_CH-1:0]             w_dup;
   logic [NUM_CH-1:0]             w_live;
   logic [CNT_W-1:0]              w_pop;
   logic [CNT_W-1:0]              r_cnt;
   logic                          w_clr;
   logic                          w_cap;
   logic                          w_unused_stall;

   assign w_mem_data     = io_bus.mem_rd_data;
   assign w_mem_addr     = io_bus.mem_rd_addr;
   assign w_unused_stall = ^io_bus.stall;

   // Flush and bubble both clear, and win over rdy=0 freezing.
   assign w_clr = io_bus.flush | (io_bus.stall[STAGE] & ~io_bus.stall[STAGE+1]);
   assign w_cap = ~w_clr & io_bus.rdy & ~io_bus.stall[STAGE];

   // A lower channel loses to any higher enabled channel targeting the same rd.
   always_comb begin
      w_dup = '0;
      for (int i = 0; i < NUM_CH; i++)
         for (int j = i + 1; j < NUM_CH; j++)
            if (io_bus.mem_rd_e[j] && (w_mem_addr[j] == w_mem_addr[i]))
               w_dup[i] = 1'b1;
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_live[i] = io_bus.mem_rd_e[i] & (w_mem_addr[i] != '0) & ~w_dup[i];
         w_pop     = w_pop + CNT_W'(w_live[i]);
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_wb_data[g] <= '0;
            r_wb_addr[g] <= '0;
            r_wb_e[g]    <= 1'b0;
         end else if (w_clr) begin
            r_wb_data[g] <= '0;
            r_wb_addr[g] <= '0;
            r_wb_e[g]    <= 1'b0;
         end else if (w_cap) begin
            r_wb_data[g] <= w_mem_data[g];
            r_wb_addr[g] <= w_mem_addr[g];
            r_wb_e[g]    <= w_live[g];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_cnt <= '0;
      else if (w_cap) r_cnt <= r_cnt + w_pop;
   end

   assign io_bus.wb_rd_data    = r_wb_data;
   assign io_bus.wb_rd_addr    = r_wb_addr;
   assign io_bus.wb_rd_e       = r_wb_e;
   assign io_bus.wb_retire_cnt = r_cnt;

`ifdef WB_FWD_EN
   logic              w_fwd_hit;
   logic [DATA_W-1:0] w_fwd_data;

   // Ascending scan so the highest matching channel wins.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (r_wb_e[i] && (r_wb_addr[i] == io_bus.fwd_addr) && (io_bus.fwd_addr != '0)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_wb_data[i];
         end
   end

   assign io_bus.fwd_hit  = w_fwd_hit;
   assign io_bus.fwd_data = w_fwd_data;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe with two channels and a 4-bit retire counter.
// Lookup-port checks run only when WB_FWD_EN is defined.
module tb_mem_wb_pipe;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;
   localparam int NUM_CH  = 2;
   localparam int STALL_W = 6;
   localparam int STAGE   = 4;
   localparam int CNT_W   = 4;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   mem_wb_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
                    .STALL_W(STALL_W), .CNT_W(CNT_W)) bus ();

   mem_wb_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
                 .STALL_W(STALL_W), .STAGE(STAGE), .CNT_W(CNT_W))
      dut (.clk(clk), .rst(rst), .io_bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] d1, input logic [4:0] a1, input logic e1,
                        input logic [31:0] d0, input logic [4:0] a0, input logic e0);
      bus.mem_rd_data = {d1, d0};
      bus.mem_rd_addr = {a1, a0};
      bus.mem_rd_e    = {e1, e0};
   endtask

   task automatic ctl(input logic rdy, input logic [5:0] stall, input logic flush);
      bus.rdy   = rdy;
      bus.stall = stall;
      bus.flush = flush;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      ctl(1'b0, 6'b000000, 1'b0);
      drive(32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);
`ifdef WB_FWD_EN
      bus.fwd_addr = '0;
`endif
      #12;
      chk("reset_e",   64'(bus.wb_rd_e),       64'h0);
      chk("reset_cnt", 64'(bus.wb_retire_cnt), 64'h0);
      rst = 1'b0;

      // T2: single live channel capture
      ctl(1'b1, 6'b000000, 1'b0);
      drive(32'h0, 5'd0, 1'b0, 32'hDEADBEEF, 5'd5, 1'b1);
      tick();
      chk("t2_data", 64'(bus.wb_rd_data[31:0]), 64'hDEADBEEF);
      chk("t2_addr", 64'(bus.wb_rd_addr[4:0]),  64'h5);
      chk("t2_e",    64'(bus.wb_rd_e),          64'h1);
      chk("t2_cnt",  64'(bus.wb_retire_cnt),    64'h1);

      // T1: reset asserted mid-cycle clears without waiting for an edge
      #2 rst = 1'b1;
      #1;
      chk("t1_e",    64'(bus.wb_rd_e),          64'h0);
      chk("t1_data", 64'(bus.wb_rd_data),       64'h0);
      chk("t1_addr", 64'(bus.wb_rd_addr),       64'h0);
      chk("t1_cnt",  64'(bus.wb_retire_cnt),    64'h0);
      rst = 1'b0;
      tick();
      chk("t1_recap_cnt", 64'(bus.wb_retire_cnt), 64'h1);

      // T3: capture, then hold on double stall and on rdy=0, then bubble
      drive(32'h0, 5'd0, 1'b0, 32'h1111, 5'd9, 1'b1);
      tick();
      chk("cap_1111_data", 64'(bus.wb_rd_data[31:0]), 64'h1111);
      chk("cap_1111_cnt",  64'(bus.wb_retire_cnt),    64'h2);
      ctl(1'b1, 6'b110000, 1'b0);
      drive(32'h0, 5'd0, 1'b0, 32'h2222, 5'd10, 1'b1);
      tick();
      chk("t3_hold_data", 64'(bus.wb_rd_data[31:0]), 64'h1111);
      chk("t3_hold_addr", 64'(bus.wb_rd_addr[4:0]),  64'h9);
      chk("t3_hold_e",    64'(bus.wb_rd_e),          64'h1);
      chk("t3_hold_cnt",  64'(bus.wb_retire_cnt),    64'h2);
      ctl(1'b0, 6'b000000, 1'b0);
      tick();
      chk("rdy0_hold_data", 64'(bus.wb_rd_data[31:0]), 64'h1111);
      chk("rdy0_hold_cnt",  64'(bus.wb_retire_cnt),    64'h2);
      ctl(1'b0, 6'b010000, 1'b0);
      tick();
      chk("t3_bubble_e",    64'(bus.wb_rd_e),       64'h0);
      chk("t3_bubble_data", 64'(bus.wb_rd_data),    64'h0);
      chk("t3_bubble_cnt",  64'(bus.wb_retire_cnt), 64'h2);

      // T4: x0 write suppressed, data still latched
      ctl(1'b1, 6'b000000, 1'b0);
      drive(32'h0, 5'd0, 1'b0, 32'h1234, 5'd0, 1'b1);
      tick();
      chk("t4_e",    64'(bus.wb_rd_e),          64'h0);
      chk("t4_data", 64'(bus.wb_rd_data[31:0]), 64'h1234);
      chk("t4_cnt",  64'(bus.wb_retire_cnt),    64'h2);

      // T5: duplicate rd, highest channel wins
      drive(32'hB, 5'd7, 1'b1, 32'hA, 5'd7, 1'b1);
      tick();
      chk("t5_e",     64'(bus.wb_rd_e),           64'h2);
      chk("t5_data0", 64'(bus.wb_rd_data[31:0]),  64'hA);
      chk("t5_data1", 64'(bus.wb_rd_data[63:32]), 64'hB);
      chk("t5_cnt",   64'(bus.wb_retire_cnt),     64'h3);

      drive(32'hC, 5'd4, 1'b1, 32'hD, 5'd3, 1'b1);
      tick();
      chk("two_live_e",   64'(bus.wb_rd_e),       64'h3);
      chk("two_live_cnt", 64'(bus.wb_retire_cnt), 64'h5);

      // Flush beats a capture-eligible cycle
      ctl(1'b1, 6'b000000, 1'b1);
      tick();
      chk("flush_e",    64'(bus.wb_rd_e),       64'h0);
      chk("flush_addr", 64'(bus.wb_rd_addr),    64'h0);
      chk("flush_cnt",  64'(bus.wb_retire_cnt), 64'h5);

      // Counter wraps: 5 + 6*2 = 17 -> 1 mod 16
      ctl(1'b1, 6'b000000, 1'b0);
      for (int k = 0; k < 6; k++) tick();
      chk("wrap_cnt", 64'(bus.wb_retire_cnt), 64'h1);

`ifdef WB_FWD_EN
      // T6: lookup port
      drive(32'h0, 5'd0, 1'b0, 32'h55, 5'd3, 1'b1);
      tick();
      bus.fwd_addr = 5'd3;
      #1;
      chk("t6_hit",  64'(bus.fwd_hit),  64'h1);
      chk("t6_data", 64'(bus.fwd_data), 64'h55);
      bus.fwd_addr = 5'd0;
      #1;
      chk("t6_x0_hit",  64'(bus.fwd_hit),  64'h0);
      chk("t6_x0_data", 64'(bus.fwd_data), 64'h0);
      bus.fwd_addr = 5'd9;
      #1;
      chk("t6_miss_hit", 64'(bus.fwd_hit), 64'h0);
      bus.fwd_addr = 5'd3;
      ctl(1'b1, 6'b000000, 1'b1);
      tick();
      chk("t6_flush_hit",  64'(bus.fwd_hit),  64'h0);
      chk("t6_flush_data", 64'(bus.fwd_data), 64'h0);
      ctl(1'b1, 6'b000000, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
